// File: rtl/irq_ctrl.sv
// Interrupt controller: samples device IRQ lines into a pending register (level or rising-edge per source),
// masks them onto hw_int/int_req for CP0, and exposes PENDING/MASK/MODE/CAUSE as a 4-word bridge device.
module irq_ctrl #(
  parameter int N_SRC = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       pr_addr,
  input  logic             wr_en,
  input  logic [31:0]      data_in,
  output logic [31:0]      data_out,
  input  logic [N_SRC-1:0] irq_src,
  output logic [N_SRC-1:0] hw_int,
  output logic             int_req
);

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_MODE    = 2'd2;
  localparam logic [1:0] ADDR_CAUSE   = 2'd3;

  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] mode;
  logic [N_SRC-1:0] irq_q;
  logic [N_SRC-1:0] irq_prev;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pending_nxt;
  logic [2:0]       cause_idx;
  logic [N_SRC-1:0] wr_data;

  assign wr_data = data_in[N_SRC-1:0];
  assign w1c     = (wr_en && pr_addr == ADDR_PENDING) ? wr_data : '0;
  assign rise    = irq_q & ~irq_prev;

  // Edge bits are sticky and a new edge beats a same-cycle clear; level bits simply follow irq_q.
  assign pending_nxt = (mode & ((pending & ~w1c) | rise)) | (~mode & irq_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      mask     <= '0;
      mode     <= '0;
      irq_q    <= '0;
      irq_prev <= '0;
    end else begin
      irq_q    <= irq_src;
      irq_prev <= irq_q;
      pending  <= pending_nxt;
      if (wr_en && pr_addr == ADDR_MASK) mask <= wr_data;
      if (wr_en && pr_addr == ADDR_MODE) mode <= wr_data;
    end
  end

  assign hw_int  = pending & mask;
  assign int_req = |hw_int;

  // Scan downward so the lowest set index is the one that survives.
  always_comb begin
    cause_idx = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (hw_int[i]) cause_idx = 3'(i);
    end
  end

  always_comb begin
    data_out = 32'd0;
    case (pr_addr)
      ADDR_PENDING: data_out = 32'(pending);
      ADDR_MASK:    data_out = 32'(mask);
      ADDR_MODE:    data_out = 32'(mode);
      ADDR_CAUSE:   data_out = {int_req, 28'd0, cause_idx};
      default:      data_out = 32'd0;
    endcase
  end

endmodule
